// File: rtl/cpu64_ooo_pkg.sv
// Shared OoO-core types: architectural/physical register widths and the ROB entry record.
package cpu64_ooo_pkg;
  localparam int ARCH_W = 5;
  localparam int PHYS_W = 6;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [ARCH_W-1:0] arch_dest;
    logic [PHYS_W-1:0] phys_dest;
    logic [PHYS_W-1:0] old_phys;
  } rob_entry_t;
endpackage

// File: rtl/rob_prefix_select.sv
// In-order commit window: selects the leading run of ready lanes and reports whether
// the first blocking lane is a completed, excepting entry.
module rob_prefix_select #(
  parameter int LANES = 2
) (
  input  logic [LANES-1:0] rdy_i,
  input  logic [LANES-1:0] exc_i,
  output logic [LANES-1:0] sel_o,
  output logic [2:0]       cnt_o,
  output logic             exc_hit_o
);
  logic run;

  always_comb begin
    sel_o     = '0;
    cnt_o     = '0;
    exc_hit_o = 1'b0;
    run       = 1'b1;
    for (int k = 0; k < LANES; k++) begin
      if (run && rdy_i[k]) begin
        sel_o[k] = 1'b1;
        cnt_o    = cnt_o + 3'd1;
      end else begin
        if (run && exc_i[k]) exc_hit_o = 1'b1;
        run = 1'b0;
      end
    end
  end
endmodule

// File: rtl/reorder_buffer_nway.sv
// N-wide reorder buffer: multi-lane in-order dispatch, out-of-order writeback, in-order commit.
// Optional precise-exception flush is enabled by defining ROB_EXC_EN.
module reorder_buffer_nway
  import cpu64_ooo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [DISPATCH_W-1:0]                      disp_valid,
  input  logic [DISPATCH_W-1:0][ARCH_W-1:0]          disp_arch_dest,
  input  logic [DISPATCH_W-1:0][PHYS_W-1:0]          disp_phys_dest,
  input  logic [DISPATCH_W-1:0][PHYS_W-1:0]          disp_old_phys,
  input  logic [DISPATCH_W-1:0][63:0]                disp_pc,
  output logic                                       disp_ready,
  output logic [DISPATCH_W-1:0][$clog2(DEPTH)-1:0]   disp_tag,
  input  logic [WB_PORTS-1:0]                        wb_valid,
  input  logic [WB_PORTS-1:0][$clog2(DEPTH)-1:0]     wb_tag,
  input  logic [WB_PORTS-1:0]                        wb_exc,
  output logic [COMMIT_W-1:0]                        commit_valid,
  output logic [COMMIT_W-1:0][ARCH_W-1:0]            commit_arch_dest,
  output logic [COMMIT_W-1:0][PHYS_W-1:0]            commit_phys_dest,
  output logic [COMMIT_W-1:0][PHYS_W-1:0]            commit_old_phys,
  output logic                                       flush,
  output logic [63:0]                                flush_pc,
  output logic [$clog2(DEPTH):0]                     count
);
  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;
  typedef logic [TAG_W-1:0] tag_t;

  rob_entry_t          ent_q [DEPTH];
  rob_entry_t          ent_d [DEPTH];
  tag_t                head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [7:0]          room;
  logic [2:0]          ndisp, ncommit;
  logic                disp_fire;
  logic [COMMIT_W-1:0] rdy, blk, sel;
  logic                exc_hit;
  logic [DEPTH-1:0]    wb_hit;

`ifdef ROB_EXC_EN
  logic [DEPTH-1:0]    exc_q, exc_d, wb_exc_hit;
  logic [63:0]         pc_q [DEPTH];
  logic                flush_q;
  logic [63:0]         flush_pc_q;
`endif

  // Room is judged on registered occupancy only; same-cycle commits are not credited.
  assign room       = 8'(DEPTH) - 8'(count_q);
  assign disp_ready = !rst && !flush && (room >= 8'(DISPATCH_W));
  assign disp_fire  = disp_ready && (|disp_valid);
  assign count      = count_q;

  for (genvar i = 0; i < DISPATCH_W; i++) begin : g_tag
    assign disp_tag[i] = tail_q + tag_t'(i);
  end

  always_comb begin
    ndisp = '0;
    for (int i = 0; i < DISPATCH_W; i++)
      if (disp_valid[i]) ndisp = ndisp + 3'd1;
  end

  for (genvar k = 0; k < COMMIT_W; k++) begin : g_win
    tag_t idx;
    assign idx = head_q + tag_t'(k);
`ifdef ROB_EXC_EN
    assign rdy[k] = ent_q[idx].valid && ent_q[idx].done && !exc_q[idx];
    assign blk[k] = ent_q[idx].valid && ent_q[idx].done &&  exc_q[idx];
`else
    assign rdy[k] = ent_q[idx].valid && ent_q[idx].done;
    assign blk[k] = 1'b0;
`endif
    assign commit_arch_dest[k] = ent_q[idx].arch_dest;
    assign commit_phys_dest[k] = ent_q[idx].phys_dest;
    assign commit_old_phys[k]  = ent_q[idx].old_phys;
  end

  rob_prefix_select #(.LANES(COMMIT_W)) u_sel (
    .rdy_i     (rdy),
    .exc_i     (blk),
    .sel_o     (sel),
    .cnt_o     (ncommit),
    .exc_hit_o (exc_hit)
  );

  assign commit_valid = rst ? '0 : sel;

  always_comb begin
    wb_hit = '0;
`ifdef ROB_EXC_EN
    wb_exc_hit = '0;
`endif
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) begin
        wb_hit[wb_tag[p]] = 1'b1;
`ifdef ROB_EXC_EN
        wb_exc_hit[wb_tag[p]] = wb_exc_hit[wb_tag[p]] | wb_exc[p];
`endif
      end
    end
  end

  // Order matters: writeback, then commit clear, then dispatch fill (disjoint entries).
  always_comb begin
    ent_d = ent_q;
`ifdef ROB_EXC_EN
    exc_d = exc_q;
`endif
    for (int e = 0; e < DEPTH; e++) begin
      if (ent_q[e].valid && wb_hit[e]) begin
        ent_d[e].done = 1'b1;
`ifdef ROB_EXC_EN
        exc_d[e] = exc_q[e] | wb_exc_hit[e];
`endif
      end
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      if (sel[k]) begin
        ent_d[head_q + tag_t'(k)] = '0;
`ifdef ROB_EXC_EN
        exc_d[head_q + tag_t'(k)] = 1'b0;
`endif
      end
    end
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (disp_fire && disp_valid[i]) begin
        ent_d[tail_q + tag_t'(i)] = '{valid: 1'b1, done: 1'b0,
                                      arch_dest: disp_arch_dest[i],
                                      phys_dest: disp_phys_dest[i],
                                      old_phys:  disp_old_phys[i]};
`ifdef ROB_EXC_EN
        exc_d[tail_q + tag_t'(i)] = 1'b0;
`endif
      end
    end
    head_d  = head_q + tag_t'(ncommit);
    tail_d  = disp_fire ? tail_q + tag_t'(ndisp) : tail_q;
    count_d = count_q + CNT_W'(disp_fire ? ndisp : 3'd0) - CNT_W'(ncommit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) ent_q[e] <= '0;
    end
`ifdef ROB_EXC_EN
    else if (exc_hit) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) ent_q[e] <= '0;
    end
`endif
    else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int e = 0; e < DEPTH; e++) ent_q[e] <= ent_d[e];
    end
  end

`ifdef ROB_EXC_EN
  // PC is payload only read on flush, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DISPATCH_W; i++)
      if (disp_fire && disp_valid[i]) pc_q[tail_q + tag_t'(i)] <= disp_pc[i];
  end

  // The squash happens on the same edge that raises flush; the pulse lasts one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_q      <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      exc_q   <= exc_hit ? '0 : exc_d;
      flush_q <= exc_hit;
      if (exc_hit) flush_pc_q <= pc_q[head_q + tag_t'(ncommit)];
    end
  end

  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;
`else
  assign flush    = 1'b0;
  assign flush_pc = '0;
  logic unused_ok;
  assign unused_ok = ^{disp_pc, wb_exc, exc_hit};
`endif
endmodule

// File: tb/tb_reorder_buffer_nway.sv
// Directed bench for reorder_buffer_nway at DEPTH=8, 2-wide dispatch/commit, 2 writeback ports.
// Exception scenario is exercised when ROB_EXC_EN is defined.
module tb_reorder_buffer_nway;
  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       disp_valid;
  logic [1:0][4:0]  disp_arch_dest;
  logic [1:0][5:0]  disp_phys_dest;
  logic [1:0][5:0]  disp_old_phys;
  logic [1:0][63:0] disp_pc;
  logic             disp_ready;
  logic [1:0][2:0]  disp_tag;
  logic [1:0]       wb_valid;
  logic [1:0][2:0]  wb_tag;
  logic [1:0]       wb_exc;
  logic [1:0]       commit_valid;
  logic [1:0][4:0]  commit_arch_dest;
  logic [1:0][5:0]  commit_phys_dest;
  logic [1:0][5:0]  commit_old_phys;
  logic             flush;
  logic [63:0]      flush_pc;
  logic [3:0]       count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  reorder_buffer_nway #(.DEPTH(8), .DISPATCH_W(2), .COMMIT_W(2), .WB_PORTS(2)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_arch_dest(disp_arch_dest), .disp_phys_dest(disp_phys_dest),
    .disp_old_phys(disp_old_phys), .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_exc(wb_exc),
    .commit_valid(commit_valid), .commit_arch_dest(commit_arch_dest),
    .commit_phys_dest(commit_phys_dest), .commit_old_phys(commit_old_phys),
    .flush(flush), .flush_pc(flush_pc), .count(count)
  );

  // Payload of instruction n: arch=n, phys=n+32, old=63-n, pc=0x1000+4n.
  task automatic drive_disp(input logic [1:0] v, input int n0, input int n1);
    disp_valid        = v;
    disp_arch_dest[0] = 5'(n0);      disp_arch_dest[1] = 5'(n1);
    disp_phys_dest[0] = 6'(n0 + 32); disp_phys_dest[1] = 6'(n1 + 32);
    disp_old_phys[0]  = 6'(63 - n0); disp_old_phys[1]  = 6'(63 - n1);
    disp_pc[0]        = 64'h1000 + 64'(4 * n0);
    disp_pc[1]        = 64'h1000 + 64'(4 * n1);
  endtask

  task automatic drive_wb(input logic [1:0] v, input int t0, input int t1, input logic [1:0] e);
    wb_valid  = v;
    wb_tag[0] = 3'(t0);
    wb_tag[1] = 3'(t1);
    wb_exc    = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_disp(2'b00, 0, 0);
    drive_wb(2'b00, 0, 0, 2'b00);
    tick(); tick();
    drive_wb(2'b11, 0, 1, 2'b00);
    #1;
    tests++; if (disp_ready !== 1'b0) begin fails++; $display("FAIL rst_disp_ready got %0b exp 0", disp_ready); end
    tests++; if (commit_valid !== 2'b00) begin fails++; $display("FAIL rst_commit_valid got %b exp 00", commit_valid); end
    tick();
    drive_wb(2'b00, 0, 0, 2'b00);
    rst = 1'b0;
    #1;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", count); end
    tests++; if (flush !== 1'b0 || flush_pc !== 64'd0) begin fails++; $display("FAIL rst_flush got %0b/%0h exp 0/0", flush, flush_pc); end
    tests++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_after got %0b exp 1", disp_ready); end
    tests++; if (disp_tag[0] !== 3'd0 || disp_tag[1] !== 3'd1) begin fails++; $display("FAIL rst_tags got %0d,%0d exp 0,1", disp_tag[0], disp_tag[1]); end
  endtask

  task automatic test_fill();
    for (int c = 0; c < 4; c++) begin
      drive_disp(2'b11, 2 * c, 2 * c + 1);
      #1;
      tests++; if (disp_tag[0] !== 3'(2 * c) || disp_tag[1] !== 3'(2 * c + 1)) begin
        fails++; $display("FAIL fill_tag c=%0d got %0d,%0d exp %0d,%0d", c, disp_tag[0], disp_tag[1], 2 * c, 2 * c + 1);
      end
      tests++; if (disp_ready !== 1'b1) begin fails++; $display("FAIL fill_ready c=%0d got %0b exp 1", c, disp_ready); end
      tick();
    end
    // Full: this dispatch must be dropped without touching entries 0/1.
    drive_disp(2'b11, 30, 31);
    #1;
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL fill_count got %0d exp 8", count); end
    tests++; if (disp_ready !== 1'b0) begin fails++; $display("FAIL fill_not_ready got %0b exp 0", disp_ready); end
    tests++; if (commit_valid !== 2'b00) begin fails++; $display("FAIL fill_no_commit got %b exp 00", commit_valid); end
    tick();
    drive_disp(2'b00, 0, 0);
    #1;
    tests++; if (count !== 4'd8 || disp_tag[0] !== 3'd0) begin fails++; $display("FAIL full_ignore got count %0d tag %0d exp 8/0", count, disp_tag[0]); end
  endtask

  task automatic test_ooo();
    drive_wb(2'b01, 1, 0, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b00) begin fails++; $display("FAIL ooo_wb1_cv got %b exp 00", commit_valid); end
    tick();
    drive_wb(2'b01, 0, 0, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b00) begin fails++; $display("FAIL ooo_same_cycle_cv got %b exp 00", commit_valid); end
    tick();
    drive_wb(2'b00, 0, 0, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b11) begin fails++; $display("FAIL ooo_cv got %b exp 11", commit_valid); end
    tests++; if (commit_arch_dest[0] !== 5'd0 || commit_arch_dest[1] !== 5'd1) begin
      fails++; $display("FAIL ooo_arch got %0d,%0d exp 0,1", commit_arch_dest[0], commit_arch_dest[1]);
    end
    tests++; if (commit_phys_dest[0] !== 6'd32 || commit_phys_dest[1] !== 6'd33 ||
                 commit_old_phys[0] !== 6'd63 || commit_old_phys[1] !== 6'd62) begin
      fails++; $display("FAIL ooo_phys got %0d,%0d old %0d,%0d exp 32,33 old 63,62",
                        commit_phys_dest[0], commit_phys_dest[1], commit_old_phys[0], commit_old_phys[1]);
    end
    tick();
    tests++; if (count !== 4'd6) begin fails++; $display("FAIL ooo_count got %0d exp 6", count); end
  endtask

  task automatic test_hole();
    drive_wb(2'b11, 2, 4, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b00) begin fails++; $display("FAIL hole_pre_cv got %b exp 00", commit_valid); end
    tick();
    drive_wb(2'b01, 3, 0, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b01 || commit_arch_dest[0] !== 5'd2) begin
      fails++; $display("FAIL hole_cv got %b arch %0d exp 01 arch 2", commit_valid, commit_arch_dest[0]);
    end
    tick();
    drive_wb(2'b11, 5, 6, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b11 || commit_arch_dest[0] !== 5'd3 || commit_arch_dest[1] !== 5'd4) begin
      fails++; $display("FAIL hole_fill_cv got %b arch %0d,%0d exp 11 arch 3,4", commit_valid, commit_arch_dest[0], commit_arch_dest[1]);
    end
    tick();
    drive_wb(2'b01, 7, 0, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b11 || commit_arch_dest[0] !== 5'd5 || commit_arch_dest[1] !== 5'd6) begin
      fails++; $display("FAIL hole_56 got %b arch %0d,%0d exp 11 arch 5,6", commit_valid, commit_arch_dest[0], commit_arch_dest[1]);
    end
    tick();
    drive_wb(2'b00, 0, 0, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b01 || commit_arch_dest[0] !== 5'd7) begin
      fails++; $display("FAIL hole_7 got %b arch %0d exp 01 arch 7", commit_valid, commit_arch_dest[0]);
    end
    tick();
    tests++; if (count !== 4'd0 || commit_valid !== 2'b00) begin
      fails++; $display("FAIL empty got count %0d cv %b exp 0/00", count, commit_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive_disp(2'b11, 8, 9);
    #1;
    tests++; if (disp_tag[0] !== 3'd0 || disp_tag[1] !== 3'd1) begin fails++; $display("FAIL b2b_tag got %0d,%0d exp 0,1", disp_tag[0], disp_tag[1]); end
    tick();
    drive_disp(2'b11, 10, 11);
    drive_wb(2'b11, 0, 1, 2'b00);
    tick();
    drive_disp(2'b11, 12, 13);
    drive_wb(2'b11, 2, 3, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b11 || commit_arch_dest[0] !== 5'd8 || commit_arch_dest[1] !== 5'd9) begin
      fails++; $display("FAIL b2b_c0 got %b arch %0d,%0d exp 11 arch 8,9", commit_valid, commit_arch_dest[0], commit_arch_dest[1]);
    end
    tick();
    drive_disp(2'b00, 0, 0);
    drive_wb(2'b11, 4, 5, 2'b00);
    #1;
    tests++; if (count !== 4'd4) begin fails++; $display("FAIL b2b_count got %0d exp 4", count); end
    tests++; if (commit_valid !== 2'b11 || commit_arch_dest[0] !== 5'd10 || commit_arch_dest[1] !== 5'd11) begin
      fails++; $display("FAIL b2b_c1 got %b arch %0d,%0d exp 11 arch 10,11", commit_valid, commit_arch_dest[0], commit_arch_dest[1]);
    end
    tick();
    drive_wb(2'b00, 0, 0, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b11 || commit_arch_dest[0] !== 5'd12 || commit_arch_dest[1] !== 5'd13) begin
      fails++; $display("FAIL b2b_c2 got %b arch %0d,%0d exp 11 arch 12,13", commit_valid, commit_arch_dest[0], commit_arch_dest[1]);
    end
    tick();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL b2b_drain got %0d exp 0", count); end
  endtask

  task automatic test_wrap();
    drive_disp(2'b11, 14, 15);
    #1;
    tests++; if (disp_tag[0] !== 3'd6 || disp_tag[1] !== 3'd7) begin fails++; $display("FAIL wrap_tag0 got %0d,%0d exp 6,7", disp_tag[0], disp_tag[1]); end
    tick();
    drive_disp(2'b11, 16, 17);
    drive_wb(2'b11, 6, 7, 2'b00);
    #1;
    tests++; if (disp_tag[0] !== 3'd0 || disp_tag[1] !== 3'd1) begin fails++; $display("FAIL wrap_tag1 got %0d,%0d exp 0,1", disp_tag[0], disp_tag[1]); end
    tick();
    drive_disp(2'b00, 0, 0);
    drive_wb(2'b11, 0, 1, 2'b00);
    #1;
    tests++; if (count !== 4'd4) begin fails++; $display("FAIL wrap_count got %0d exp 4", count); end
    tests++; if (commit_valid !== 2'b11 || commit_arch_dest[0] !== 5'd14 || commit_arch_dest[1] !== 5'd15) begin
      fails++; $display("FAIL wrap_c67 got %b arch %0d,%0d exp 11 arch 14,15", commit_valid, commit_arch_dest[0], commit_arch_dest[1]);
    end
    tick();
    drive_wb(2'b00, 0, 0, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b11 || commit_arch_dest[0] !== 5'd16 || commit_arch_dest[1] !== 5'd17) begin
      fails++; $display("FAIL wrap_c01 got %b arch %0d,%0d exp 11 arch 16,17", commit_valid, commit_arch_dest[0], commit_arch_dest[1]);
    end
    tick();
    tests++; if (count !== 4'd0 || commit_valid !== 2'b00) begin fails++; $display("FAIL wrap_end got count %0d cv %b exp 0/00", count, commit_valid); end
  endtask

  task automatic test_reset_mid();
    drive_disp(2'b11, 18, 19);
    #1;
    tests++; if (disp_tag[0] !== 3'd2) begin fails++; $display("FAIL mid_tag got %0d exp 2", disp_tag[0]); end
    tick();
    drive_disp(2'b11, 20, 21);
    tick();
    drive_disp(2'b01, 22, 0);
    tick();
    drive_disp(2'b00, 0, 0);
    drive_wb(2'b01, 2, 0, 2'b00);
    #1;
    tests++; if (count !== 4'd5) begin fails++; $display("FAIL mid_count got %0d exp 5", count); end
    tick();
    drive_wb(2'b00, 0, 0, 2'b00);
    rst = 1'b1;
    #1;
    tests++; if (commit_valid !== 2'b00 || disp_ready !== 1'b0) begin
      fails++; $display("FAIL mid_rst_hold got cv %b ready %0b exp 00/0", commit_valid, disp_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    tests++; if (count !== 4'd0 || commit_valid !== 2'b00 || flush !== 1'b0) begin
      fails++; $display("FAIL mid_rst got count %0d cv %b flush %0b exp 0/00/0", count, commit_valid, flush);
    end
    tests++; if (disp_tag[0] !== 3'd0 || disp_ready !== 1'b1) begin
      fails++; $display("FAIL mid_rst_tag got %0d ready %0b exp 0/1", disp_tag[0], disp_ready);
    end
    drive_disp(2'b01, 1, 0);
    tick();
    drive_disp(2'b00, 0, 0);
    #1;
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL mid_redisp got %0d exp 1", count); end
  endtask

`ifdef ROB_EXC_EN
  task automatic test_exc();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_disp(2'b11, 0, 1);
    tick();
    drive_disp(2'b00, 0, 0);
    drive_wb(2'b11, 0, 1, 2'b10);
    tick();
    drive_wb(2'b00, 0, 0, 2'b00);
    #1;
    tests++; if (commit_valid !== 2'b01 || commit_arch_dest[0] !== 5'd0 || flush !== 1'b0) begin
      fails++; $display("FAIL exc_commit got cv %b arch %0d flush %0b exp 01/0/0", commit_valid, commit_arch_dest[0], flush);
    end
    tick();
    tests++; if (flush !== 1'b1 || flush_pc !== 64'h1004) begin
      fails++; $display("FAIL exc_flush got %0b pc %0h exp 1 pc 1004", flush, flush_pc);
    end
    tests++; if (commit_valid !== 2'b00 || disp_ready !== 1'b0) begin
      fails++; $display("FAIL exc_flush_hold got cv %b ready %0b exp 00/0", commit_valid, disp_ready);
    end
    tick();
    tests++; if (flush !== 1'b0 || count !== 4'd0 || disp_ready !== 1'b1 || disp_tag[0] !== 3'd0) begin
      fails++; $display("FAIL exc_after got flush %0b count %0d ready %0b tag %0d exp 0/0/1/0", flush, count, disp_ready, disp_tag[0]);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_ooo();
    test_hole();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
`ifdef ROB_EXC_EN
    test_exc();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
